rf_wb_arbiter: RTL and testbench



---
 rtl/rf_wb_arbiter_pkg.sv | 16 +
 rtl/rf_wb_arbiter_if.sv | 44 ++++
 rtl/rf_wb_arbiter_fifo.sv | 99 +++++++++
 rtl/rf_wb_arbiter.sv | 149 ++++++++++++++
 tb/tb_rf_wb_arbiter.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/rf_wb_arbiter_pkg.sv
// rf_wb_arbiter shared types and constants.
// Widths match the register-file word and address.
package rf_wb_pkg;

  localparam int DATA_W = 17;
  localparam int ADDR_W = 4;

  localparam logic [ADDR_W-1:0] ZERO_REG = '0;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              kill;
  } wb_entry_t;

endpackage

// File: rtl/rf_wb_arbiter_if.sv
// Write-back bus: ALU/load inputs, register-file write port,
// and the hazard lookup ports.
interface rf_wb_arbiter_if;
  import rf_wb_pkg::*;

  logic              alu_valid;
  logic [ADDR_W-1:0] alu_addr;
  logic [DATA_W-1:0] alu_data;

  logic              mem_valid;
  logic              mem_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;

  logic              stall_req;

  logic              wb_we;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;

  logic [ADDR_W-1:0] q0_addr;
  logic [ADDR_W-1:0] q1_addr;
  logic              q0_pend;
  logic              q1_pend;

  modport master (
    output alu_valid, alu_addr, alu_data,
    output mem_valid, mem_addr, mem_data,
    output q0_addr, q1_addr,
    input  mem_ready, stall_req,
    input  wb_we, wb_addr, wb_data,
    input  q0_pend, q1_pend
  );

  modport slave (
    input  alu_valid, alu_addr, alu_data,
    input  mem_valid, mem_addr, mem_data,
    input  q0_addr, q1_addr,
    output mem_ready, stall_req,
    output wb_we, wb_addr, wb_data,
    output q0_pend, q1_pend
  );

endinterface

// File: rtl/rf_wb_arbiter_fifo.sv
// Load-result FIFO with kill-by-address and per-entry
// live/address match vectors for hazard lookup.
module rf_wb_fifo
  import rf_wb_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int IW    = $clog2(DEPTH),
  localparam int PW    = IW + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  wb_entry_t         push_entry,
  input  logic              pop,
  input  logic              kill_en,
  input  logic [ADDR_W-1:0] kill_addr,
  input  logic [ADDR_W-1:0] q0_addr,
  input  logic [ADDR_W-1:0] q1_addr,
  output wb_entry_t         head,
  output logic [PW-1:0]     count,
  output logic              empty,
  output logic              full,
  output logic [DEPTH-1:0]  q0_match,
  output logic [DEPTH-1:0]  q1_match
);

  wb_entry_t        mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [IW-1:0]    wr_idx;
  logic [IW-1:0]    rd_idx;
  logic [DEPTH-1:0] live;
  logic             push_kill;

  assign wr_idx = wr_ptr[IW-1:0];
  assign rd_idx = rd_ptr[IW-1:0];
  assign count  = wr_ptr - rd_ptr;
  assign empty  = (wr_ptr == rd_ptr);
  assign full   = (wr_ptr[IW] != rd_ptr[IW])
               && (wr_idx == rd_idx);
  assign head   = mem[rd_idx];

  // A same-cycle ALU write is younger than the pushed load.
  assign push_kill = push_entry.kill
                  || (kill_en
                  && push_entry.addr == kill_addr);

  for (genvar g = 0; g < DEPTH; g++) begin : g_slot
    logic [IW-1:0] off;
    assign off = IW'(g) - rd_idx;
    assign live[g] = ({1'b0, off} < count)
                  && !mem[g].kill;
    assign q0_match[g] = live[g]
                      && (mem[g].addr == q0_addr);
    assign q1_match[g] = live[g]
                      && (mem[g].addr == q1_addr);
  end

  // Storage, kill flags and pointer updates.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (kill_en) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (mem[i].addr == kill_addr) begin
            mem[i].kill <= 1'b1;
          end
        end
      end
      if (push) begin
        mem[wr_idx] <= '{
          addr: push_entry.addr,
          data: push_entry.data,
          kill: push_kill
        };
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  a_no_push_full: assert property (
    @(posedge clk) disable iff (rst)
    !(push && full)
  ) else $error("push while fifo full");

  a_no_pop_empty: assert property (
    @(posedge clk) disable iff (rst)
    !(pop && empty)
  ) else $error("pop while fifo empty");

endmodule

// File: rtl/rf_wb_arbiter.sv
// Write-back arbiter: ALU has priority, loads buffered.
// Optional macro RF_WB_BYPASS_EN: empty-FIFO load bypass.
module rf_wb_arbiter
  import rf_wb_pkg::*;
#(
  parameter  int DEPTH        = 4,
  parameter  int STARVE_LIMIT = 3,
  localparam int PW = $clog2(DEPTH) + 1,
  localparam int SW = $clog2(STARVE_LIMIT + 1)
) (
  input logic            clk,
  input logic            rst,
  rf_wb_arbiter_if.slave bus
);

  wb_entry_t         head;
  wb_entry_t         push_entry;
  logic [PW-1:0]     count;
  logic [PW-1:0]     count_nxt;
  logic              empty;
  logic              full;
  logic [DEPTH-1:0]  q0_match;
  logic [DEPTH-1:0]  q1_match;

  logic              mem_acc;
  logic              push;
  logic              pop;
  logic              bypass;
  logic              alu_wr;
  logic              head_live;

  logic [SW-1:0]     starve;
  logic [SW-1:0]     starve_nxt;
  logic              stall_req;

  logic              wb_we;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;

  assign mem_acc   = bus.mem_valid && !full;
  assign alu_wr    = bus.alu_valid
                  && (bus.alu_addr != ZERO_REG);
  assign pop       = !bus.alu_valid && !empty;
  assign head_live = !empty && !head.kill;

`ifdef RF_WB_BYPASS_EN
  assign bypass = mem_acc && empty
               && !bus.alu_valid;
`else
  assign bypass = 1'b0;
`endif

  assign push = mem_acc && !bypass;

  // r0 loads are pushed already dead so the
  // handshake looks the same for every address.
  assign push_entry = '{
    addr: bus.mem_addr,
    data: bus.mem_data,
    kill: (bus.mem_addr == ZERO_REG)
  };

  assign count_nxt = count + PW'(push) - PW'(pop);

  rf_wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .kill_en    (alu_wr),
    .kill_addr  (bus.alu_addr),
    .q0_addr    (bus.q0_addr),
    .q1_addr    (bus.q1_addr),
    .head       (head),
    .count      (count),
    .empty      (empty),
    .full       (full),
    .q0_match   (q0_match),
    .q1_match   (q1_match)
  );

  // Starvation count: ALU keeps beating a live head.
  always_comb begin
    starve_nxt = starve;
    if (pop || empty) begin
      starve_nxt = '0;
    end else if (bus.alu_valid && head_live
              && starve != SW'(STARVE_LIMIT)) begin
      starve_nxt = starve + 1'b1;
    end
  end

  // Starve counter and registered stall request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve    <= '0;
      stall_req <= 1'b0;
    end else begin
      starve    <= starve_nxt;
      stall_req <= (starve_nxt == SW'(STARVE_LIMIT))
                || (count_nxt == PW'(DEPTH));
    end
  end

  // Write-port registers: ALU, then FIFO head, then bypass.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_we   <= 1'b0;
      wb_addr <= '0;
      wb_data <= '0;
    end else if (bus.alu_valid) begin
      wb_we   <= alu_wr;
      wb_addr <= bus.alu_addr;
      wb_data <= bus.alu_data;
    end else if (pop) begin
      wb_we   <= !head.kill;
      wb_addr <= head.addr;
      wb_data <= head.data;
    end else if (bypass) begin
      wb_we   <= (bus.mem_addr != ZERO_REG);
      wb_addr <= bus.mem_addr;
      wb_data <= bus.mem_data;
    end else begin
      wb_we   <= 1'b0;
    end
  end

  assign bus.mem_ready = !full;
  assign bus.stall_req = stall_req;
  assign bus.wb_we     = wb_we;
  assign bus.wb_addr   = wb_addr;
  assign bus.wb_data   = wb_data;

  assign bus.q0_pend = (bus.q0_addr != ZERO_REG)
                    && ((|q0_match)
                    || (wb_we && wb_addr == bus.q0_addr));
  assign bus.q1_pend = (bus.q1_addr != ZERO_REG)
                    && ((|q1_match)
                    || (wb_we && wb_addr == bus.q1_addr));

  a_no_alu_on_stall: assert property (
    @(posedge clk) disable iff (rst)
    !(bus.alu_valid && stall_req)
  ) else $error("alu_valid while stall_req");

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter.
// Table of vectors plus reset and pend/bypass sequences.
module tb_rf_wb_arbiter;
  import rf_wb_pkg::*;

  localparam int NV = 26;

  typedef struct {
    logic              av;
    logic [ADDR_W-1:0] aa;
    logic [DATA_W-1:0] ad;
    logic              mv;
    logic [ADDR_W-1:0] ma;
    logic [DATA_W-1:0] md;
    logic [ADDR_W-1:0] q0;
    logic [ADDR_W-1:0] q1;
    logic              we;
    logic [ADDR_W-1:0] wa;
    logic [DATA_W-1:0] wd;
    logic              rdy;
    logic              stl;
    logic              p0;
    logic              p1;
  } vec_t;

  logic clk;
  logic rst;
  int   tests;
  int   fails;
  vec_t vt [NV];

  rf_wb_arbiter_if bus ();

  rf_wb_arbiter #(
    .DEPTH        (4),
    .STARVE_LIMIT (3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic vec_t mk(
    int av, int aa, int ad, int mv, int ma, int md,
    int q0, int q1, int we, int wa, int wd,
    int rdy, int stl, int p0, int p1);
    vec_t v;
    v.av  = 1'(av);
    v.aa  = ADDR_W'(aa);
    v.ad  = DATA_W'(ad);
    v.mv  = 1'(mv);
    v.ma  = ADDR_W'(ma);
    v.md  = DATA_W'(md);
    v.q0  = ADDR_W'(q0);
    v.q1  = ADDR_W'(q1);
    v.we  = 1'(we);
    v.wa  = ADDR_W'(wa);
    v.wd  = DATA_W'(wd);
    v.rdy = 1'(rdy);
    v.stl = 1'(stl);
    v.p0  = 1'(p0);
    v.p1  = 1'(p1);
    return v;
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.alu_valid = v.av;
    bus.alu_addr  = v.aa;
    bus.alu_data  = v.ad;
    bus.mem_valid = v.mv;
    bus.mem_addr  = v.ma;
    bus.mem_data  = v.md;
    bus.q0_addr   = v.q0;
    bus.q1_addr   = v.q1;
  endtask

  task automatic idle(input int q0, input int q1);
    drive(mk(0, 0, 0, 0, 0, 0, q0, q1,
             0, 0, 0, 0, 0, 0, 0));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst   = 1'b1;
    idle(0, 0);

    // av aa ad  mv ma md  q0 q1 | we wa wd rdy stl p0 p1
    // ALU only
    vt[0]  = mk(1, 5, 'h1ABCD, 0, 0, 0, 5, 0,
                1, 5, 'h1ABCD, 1, 0, 1, 0);
    vt[1]  = mk(1, 0, 'h00FFF, 0, 0, 0, 5, 0,
                0, 0, 0, 1, 0, 0, 0);
    vt[2]  = mk(0, 0, 0, 0, 0, 0, 0, 0,
                0, 0, 0, 1, 0, 0, 0);
    // fill with ALU busy, then drain in order
    vt[3]  = mk(1, 10, 'h0A0A0, 1, 1, 'h10001, 1, 10,
                1, 10, 'h0A0A0, 1, 0, 1, 1);
    vt[4]  = mk(1, 10, 'h0A0A0, 1, 2, 'h10002, 2, 3,
                1, 10, 'h0A0A0, 1, 0, 1, 0);
    vt[5]  = mk(1, 10, 'h0A0A0, 1, 3, 'h10003, 3, 4,
                1, 10, 'h0A0A0, 1, 0, 1, 0);
    vt[6]  = mk(1, 10, 'h0A0A0, 1, 4, 'h10004, 4, 1,
                1, 10, 'h0A0A0, 0, 1, 1, 1);
    vt[7]  = mk(0, 0, 0, 1, 6, 'h00666, 6, 1,
                1, 1, 'h10001, 1, 0, 0, 1);
    vt[8]  = mk(0, 0, 0, 0, 0, 0, 1, 2,
                1, 2, 'h10002, 1, 0, 0, 1);
    vt[9]  = mk(0, 0, 0, 0, 0, 0, 3, 4,
                1, 3, 'h10003, 1, 0, 1, 1);
    vt[10] = mk(0, 0, 0, 0, 0, 0, 4, 3,
                1, 4, 'h10004, 1, 0, 1, 0);
    vt[11] = mk(0, 0, 0, 0, 0, 0, 4, 0,
                0, 0, 0, 1, 0, 0, 0);
    // kill of a buffered load
    vt[12] = mk(1, 12, 'h00C0C, 1, 7, 'h00011, 7, 12,
                1, 12, 'h00C0C, 1, 0, 1, 1);
    vt[13] = mk(1, 7, 'h00022, 0, 0, 0, 7, 12,
                1, 7, 'h00022, 1, 0, 1, 0);
    vt[14] = mk(0, 0, 0, 0, 0, 0, 7, 0,
                0, 0, 0, 1, 0, 0, 0);
    // same-cycle kill
    vt[15] = mk(1, 7, 'h00022, 1, 7, 'h00011, 7, 0,
                1, 7, 'h00022, 1, 0, 1, 0);
    vt[16] = mk(0, 0, 0, 0, 0, 0, 7, 0,
                0, 0, 0, 1, 0, 0, 0);
    vt[17] = mk(0, 0, 0, 0, 0, 0, 7, 0,
                0, 0, 0, 1, 0, 0, 0);
    // starvation
    vt[18] = mk(1, 13, 'h00013, 1, 8, 'h00088, 8, 13,
                1, 13, 'h00013, 1, 0, 1, 1);
    vt[19] = mk(1, 13, 'h00013, 0, 0, 0, 8, 0,
                1, 13, 'h00013, 1, 0, 1, 0);
    vt[20] = mk(1, 13, 'h00013, 0, 0, 0, 8, 0,
                1, 13, 'h00013, 1, 0, 1, 0);
    vt[21] = mk(1, 13, 'h00013, 0, 0, 0, 8, 0,
                1, 13, 'h00013, 1, 1, 1, 0);
    vt[22] = mk(0, 0, 0, 0, 0, 0, 8, 0,
                1, 8, 'h00088, 1, 0, 1, 0);
    vt[23] = mk(0, 0, 0, 0, 0, 0, 8, 0,
                0, 0, 0, 1, 0, 0, 0);
    // r0 load is pushed dead
    vt[24] = mk(1, 14, 'h00014, 1, 0, 'h0AAAA, 0, 14,
                1, 14, 'h00014, 1, 0, 0, 1);
    vt[25] = mk(0, 0, 0, 0, 0, 0, 0, 14,
                0, 0, 0, 1, 0, 0, 0);

    #1;
    chk("reset wb_we", 32'(bus.wb_we), 0);
    chk("reset wb_addr", 32'(bus.wb_addr), 0);
    chk("reset wb_data", 32'(bus.wb_data), 0);
    chk("reset mem_ready", 32'(bus.mem_ready), 1);
    chk("reset stall_req", 32'(bus.stall_req), 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      drive(vt[i]);
      tick();
      chk($sformatf("v%0d wb_we", i),
          32'(bus.wb_we), 32'(vt[i].we));
      if (vt[i].we) begin
        chk($sformatf("v%0d wb_addr", i),
            32'(bus.wb_addr), 32'(vt[i].wa));
        chk($sformatf("v%0d wb_data", i),
            32'(bus.wb_data), 32'(vt[i].wd));
      end
      chk($sformatf("v%0d mem_ready", i),
          32'(bus.mem_ready), 32'(vt[i].rdy));
      chk($sformatf("v%0d stall_req", i),
          32'(bus.stall_req), 32'(vt[i].stl));
      chk($sformatf("v%0d q0_pend", i),
          32'(bus.q0_pend), 32'(vt[i].p0));
      chk($sformatf("v%0d q1_pend", i),
          32'(bus.q1_pend), 32'(vt[i].p1));
    end

    // reset with three loads buffered
    for (int k = 1; k <= 3; k++) begin
      drive(mk(1, 11, 'h00B0B, 1, k, 'h00100 + k, 2, 11,
               0, 0, 0, 0, 0, 0, 0));
      tick();
    end
    chk("pre-rst q0_pend", 32'(bus.q0_pend), 1);
    chk("pre-rst q1_pend", 32'(bus.q1_pend), 1);
    #2;
    rst = 1'b1;
    #1;
    chk("rst wb_we", 32'(bus.wb_we), 0);
    chk("rst mem_ready", 32'(bus.mem_ready), 1);
    chk("rst stall_req", 32'(bus.stall_req), 0);
    chk("rst q0_pend", 32'(bus.q0_pend), 0);
    chk("rst q1_pend", 32'(bus.q1_pend), 0);
    idle(2, 3);
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk("post-rst wb_we", 32'(bus.wb_we), 0);
    chk("post-rst q0_pend", 32'(bus.q0_pend), 0);
    chk("post-rst q1_pend", 32'(bus.q1_pend), 0);

    // pend tracking for load to r9
    drive(mk(0, 0, 0, 1, 9, 'h00099, 9, 0,
             0, 0, 0, 0, 0, 0, 0));
    #1;
    chk("pend9 before", 32'(bus.q0_pend), 0);
    tick();
`ifdef RF_WB_BYPASS_EN
    chk("byp9 wb_we", 32'(bus.wb_we), 1);
    chk("byp9 wb_addr", 32'(bus.wb_addr), 9);
    chk("byp9 wb_data", 32'(bus.wb_data), 'h99);
    chk("byp9 q0_pend", 32'(bus.q0_pend), 1);
    idle(9, 0);
    tick();
    chk("byp9 done we", 32'(bus.wb_we), 0);
    chk("byp9 done pend", 32'(bus.q0_pend), 0);
`else
    chk("ld9 e1 wb_we", 32'(bus.wb_we), 0);
    chk("ld9 e1 q0_pend", 32'(bus.q0_pend), 1);
    idle(9, 0);
    tick();
    chk("ld9 e2 wb_we", 32'(bus.wb_we), 1);
    chk("ld9 e2 wb_addr", 32'(bus.wb_addr), 9);
    chk("ld9 e2 wb_data", 32'(bus.wb_data), 'h99);
    chk("ld9 e2 q0_pend", 32'(bus.q0_pend), 1);
    tick();
    chk("ld9 e3 wb_we", 32'(bus.wb_we), 0);
    chk("ld9 e3 q0_pend", 32'(bus.q0_pend), 0);
`endif

    // r0 load with ALU idle never writes
    drive(mk(0, 0, 0, 1, 0, 'h00123, 0, 0,
             0, 0, 0, 0, 0, 0, 0));
    tick();
    chk("r0ld e1 wb_we", 32'(bus.wb_we), 0);
    idle(0, 0);
    tick();
    chk("r0ld e2 wb_we", 32'(bus.wb_we), 0);
    chk("r0ld mem_ready", 32'(bus.mem_ready), 1);

    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

endmodule
